// File: rtl/countdown_controller_if.sv
// ---------------------------------------------------------------------------
// countdown_controller_if
//   User-side bus of the MM:SS countdown controller. The debounced user
//   controls and the load digits come in; the BCD count and the status
//   flags go out to the seven-segment display driver.
//
//   master : user side (debouncers / display driver, or a testbench)
//   slave  : countdown_controller
//
//   loadValid                      one-cycle pulse, latch the load digits
//   loadMinTens..loadSecOnes [3:0] BCD digits to load
//   startStop                      one-cycle pulse, start/pause/resume/ack
//   clearReq                       one-cycle pulse, abort and zero the count
//   minTens..secOnes         [3:0] current count, BCD
//   running                        high while counting down
//   alarm                          high while the alarm is sounding
//   loadError                      one-cycle pulse, load rejected
// ---------------------------------------------------------------------------
interface countdown_controller_if;
  logic       loadValid;
  logic [3:0] loadMinTens;
  logic [3:0] loadMinOnes;
  logic [3:0] loadSecTens;
  logic [3:0] loadSecOnes;
  logic       startStop;
  logic       clearReq;

  logic [3:0] minTens;
  logic [3:0] minOnes;
  logic [3:0] secTens;
  logic [3:0] secOnes;
  logic       running;
  logic       alarm;
  logic       loadError;

  modport master (
    output loadValid, loadMinTens, loadMinOnes, loadSecTens, loadSecOnes,
    output startStop, clearReq,
    input  minTens, minOnes, secTens, secOnes, running, alarm, loadError
  );

  modport slave (
    input  loadValid, loadMinTens, loadMinOnes, loadSecTens, loadSecOnes,
    input  startStop, clearReq,
    output minTens, minOnes, secTens, secOnes, running, alarm, loadError
  );
endinterface

// File: rtl/countdown_controller.sv
// ---------------------------------------------------------------------------
// countdown_controller
//   MM:SS countdown held as four BCD digits. Consumes the one-second marker
//   of the seconds Timer and drives that Timer's enable and clear inputs.
//   Supports load (range-checked), start/pause/resume, clear and a timed
//   alarm that sounds for ALARM_SECONDS seconds after the count expires.
//
//   Parameters
//     MAX_MINUTES    largest loadable minutes value
//     ALARM_SECONDS  seconds the alarm stays asserted after expiry (1..15)
//
//   Ports
//     clock         system clock
//     reset         asynchronous reset, active low
//     secondMarker  Timer terminal-count level, held until the Timer is cleared
//     timerEnable   to Timer isEnabled
//     timerClear    to Timer reset (active high, synchronous in the Timer)
//     bus           user-side bus (countdown_controller_if.slave)
//
//   Every output is registered: it changes on the clock edge after the
//   input that caused it.
// ---------------------------------------------------------------------------
module countdown_controller #(
  parameter int MAX_MINUTES   = 59,
  parameter int ALARM_SECONDS = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 secondMarker,
  output logic                 timerEnable,
  output logic                 timerClear,
  countdown_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } stateT;

  stateT      state;
  logic [3:0] minTensQ;
  logic [3:0] minOnesQ;
  logic [3:0] secTensQ;
  logic [3:0] secOnesQ;
  logic       runningQ;
  logic       alarmQ;
  logic       loadErrorQ;
  logic       markerPrev;
  logic [3:0] alarmCount;

  // One-cycle tick on the rising edge of the marker. The Timer keeps the
  // marker high until it is cleared, so a held level must not tick again.
  logic tick;
  assign tick = secondMarker & ~markerPrev;

  logic countIsZero;
  assign countIsZero = (minTensQ == 4'd0) && (minOnesQ == 4'd0) &&
                       (secTensQ == 4'd0) && (secOnesQ == 4'd0);

  // -------------------------------------------------------------------------
  // Count minus one second, with the BCD borrow chain
  //   secOnes 0 -> 9 borrows from secTens, secTens 0 -> 5 borrows from
  //   minutes, minOnes 0 -> 9 borrows from minTens.
  // Only used while the count is non-zero, so minTens never underflows.
  // -------------------------------------------------------------------------
  logic [3:0] decMinTens;
  logic [3:0] decMinOnes;
  logic [3:0] decSecTens;
  logic [3:0] decSecOnes;
  logic       decIsZero;

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the
    // block leaves one unassigned and no latch is inferred.
    decMinTens = minTensQ;
    decMinOnes = minOnesQ;
    decSecTens = secTensQ;
    decSecOnes = secOnesQ;
    if (secOnesQ != 4'd0) begin
      decSecOnes = secOnesQ - 4'd1;
    end else begin
      decSecOnes = 4'd9;
      if (secTensQ != 4'd0) begin
        decSecTens = secTensQ - 4'd1;
      end else begin
        decSecTens = 4'd5;
        if (minOnesQ != 4'd0) begin
          decMinOnes = minOnesQ - 4'd1;
        end else begin
          decMinOnes = 4'd9;
          decMinTens = minTensQ - 4'd1;
        end
      end
    end
    decIsZero = (decMinTens == 4'd0) && (decMinOnes == 4'd0) &&
                (decSecTens == 4'd0) && (decSecOnes == 4'd0);
  end

  // -------------------------------------------------------------------------
  // Load validation: every digit must be BCD, seconds tens at most 5, and
  // the minutes value no larger than MAX_MINUTES. The minutes value is
  // formed in 8 bits so that non-BCD digits cannot wrap into range.
  // -------------------------------------------------------------------------
  logic [7:0] loadMinutes;
  logic       loadOk;

  always_comb begin
    loadMinutes = 8'(bus.loadMinTens) * 8'd10 + 8'(bus.loadMinOnes);
    loadOk      = (bus.loadMinTens <= 4'd9) && (bus.loadMinOnes <= 4'd9) &&
                  (bus.loadSecTens <= 4'd5) && (bus.loadSecOnes <= 4'd9) &&
                  (int'(loadMinutes) <= MAX_MINUTES);
  end

  // -------------------------------------------------------------------------
  // Controller FSM with registered outputs.
  //   timerClear defaults to the tick so every marker rise re-arms the Timer
  //   in any state; starting from IDLE and clearing also pulse it, resuming
  //   from PAUSED does not, so the partial second is kept.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      minTensQ    <= 4'd0;
      minOnesQ    <= 4'd0;
      secTensQ    <= 4'd0;
      secOnesQ    <= 4'd0;
      timerEnable <= 1'b0;
      timerClear  <= 1'b1;
      runningQ    <= 1'b0;
      alarmQ      <= 1'b0;
      loadErrorQ  <= 1'b0;
      markerPrev  <= 1'b0;
      alarmCount  <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments throughout: every right-hand side
      // sees the pre-edge value, and later assignments in the block simply
      // override the defaults below.
      markerPrev <= secondMarker;
      timerClear <= tick;
      loadErrorQ <= 1'b0;

      if (bus.clearReq) begin
        state       <= IDLE;
        minTensQ    <= 4'd0;
        minOnesQ    <= 4'd0;
        secTensQ    <= 4'd0;
        secOnesQ    <= 4'd0;
        timerEnable <= 1'b0;
        timerClear  <= 1'b1;
        runningQ    <= 1'b0;
        alarmQ      <= 1'b0;
        alarmCount  <= 4'd0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.startStop && !countIsZero) begin
              // Clear the Timer so the first second is a full one.
              state       <= RUNNING;
              timerEnable <= 1'b1;
              timerClear  <= 1'b1;
              runningQ    <= 1'b1;
            end else if (bus.loadValid) begin
              if (loadOk) begin
                minTensQ <= bus.loadMinTens;
                minOnesQ <= bus.loadMinOnes;
                secTensQ <= bus.loadSecTens;
                secOnesQ <= bus.loadSecOnes;
              end else begin
                loadErrorQ <= 1'b1;
              end
            end
          end

          RUNNING: begin
            if (tick) begin
              minTensQ <= decMinTens;
              minOnesQ <= decMinOnes;
              secTensQ <= decSecTens;
              secOnesQ <= decSecOnes;
            end
            // Expiry wins over a simultaneous pause request.
            if (tick && decIsZero) begin
              state      <= EXPIRED;
              alarmCount <= 4'(ALARM_SECONDS);
              alarmQ     <= 1'b1;
              runningQ   <= 1'b0;
            end else if (bus.startStop) begin
              state       <= PAUSED;
              timerEnable <= 1'b0;
              runningQ    <= 1'b0;
            end
          end

          PAUSED: begin
            if (bus.startStop) begin
              state       <= RUNNING;
              timerEnable <= 1'b1;
              runningQ    <= 1'b1;
            end
          end

          EXPIRED: begin
            // The Timer keeps running to time the alarm duration.
            if (bus.startStop || (tick && alarmCount <= 4'd1)) begin
              state       <= IDLE;
              alarmQ      <= 1'b0;
              timerEnable <= 1'b0;
              alarmCount  <= 4'd0;
            end else if (tick) begin
              alarmCount <= alarmCount - 4'd1;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.minTens   = minTensQ;
  assign bus.minOnes   = minOnesQ;
  assign bus.secTens   = secTensQ;
  assign bus.secOnes   = secOnesQ;
  assign bus.running   = runningQ;
  assign bus.alarm     = alarmQ;
  assign bus.loadError = loadErrorQ;

endmodule

// File: tb/tb_countdown_controller.sv
// ---------------------------------------------------------------------------
// tb_countdown_controller
//   Directed bench for countdown_controller (MAX_MINUTES 59, ALARM_SECONDS 5).
//   Inputs change 1 ns after the rising edge; outputs are sampled at the
//   same point, so each sample shows the result of the preceding edge.
// ---------------------------------------------------------------------------
module tb_countdown_controller;

  logic clock;
  logic reset;
  logic secondMarker;
  logic timerEnable;
  logic timerClear;

  int checks;
  int errors;

  countdown_controller_if bus ();

  countdown_controller #(
    .MAX_MINUTES   (59),
    .ALARM_SECONDS (5)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .secondMarker (secondMarker),
    .timerEnable  (timerEnable),
    .timerClear   (timerClear),
    .bus          (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock edge and land 1 ns after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] observed,
                       input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed,
                          input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] count();
    return {bus.minTens, bus.minOnes, bus.secTens, bus.secOnes};
  endfunction

  task automatic load(input logic [3:0] mt, input logic [3:0] mo,
                      input logic [3:0] st, input logic [3:0] so);
    bus.loadValid   = 1'b1;
    bus.loadMinTens = mt;
    bus.loadMinOnes = mo;
    bus.loadSecTens = st;
    bus.loadSecOnes = so;
    step();
    bus.loadValid = 1'b0;
  endtask

  task automatic pulseStart();
    bus.startStop = 1'b1;
    step();
    bus.startStop = 1'b0;
  endtask

  task automatic pulseClear();
    bus.clearReq = 1'b1;
    step();
    bus.clearReq = 1'b0;
  endtask

  // One marker rise held for three cycles, then released.
  task automatic fullTick();
    secondMarker = 1'b1;
    step();
    step();
    step();
    secondMarker = 1'b0;
    step();
  endtask

  logic [15:0] expDown [6];

  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b0;
    secondMarker    = 1'b0;
    bus.loadValid   = 1'b0;
    bus.loadMinTens = 4'd0;
    bus.loadMinOnes = 4'd0;
    bus.loadSecTens = 4'd0;
    bus.loadSecOnes = 4'd0;
    bus.startStop   = 1'b0;
    bus.clearReq    = 1'b0;
    expDown = '{16'h0104, 16'h0103, 16'h0102, 16'h0101, 16'h0100, 16'h0059};

    // 1) Reset state, then release.
    step();
    step();
    checkBit("rst timerClear", timerClear, 1'b1);
    check("rst count", count(), 16'h0000);
    checkBit("rst alarm", bus.alarm, 1'b0);
    checkBit("rst timerEnable", timerEnable, 1'b0);
    checkBit("rst running", bus.running, 1'b0);
    checkBit("rst loadError", bus.loadError, 1'b0);
    reset = 1'b1;
    step();
    checkBit("rel timerClear", timerClear, 1'b0);
    check("rel count", count(), 16'h0000);

    // 2) 01:05 down to 00:59 over six held marker rises.
    load(4'd0, 4'd1, 4'd0, 4'd5);
    check("ld0105 count", count(), 16'h0105);
    checkBit("ld0105 err", bus.loadError, 1'b0);
    pulseStart();
    checkBit("start running", bus.running, 1'b1);
    checkBit("start timerEnable", timerEnable, 1'b1);
    checkBit("start timerClear", timerClear, 1'b1);
    step();
    checkBit("start clr drop", timerClear, 1'b0);
    for (int i = 0; i < 6; i++) begin
      secondMarker = 1'b1;
      step();
      check("down count", count(), expDown[i]);
      checkBit("down clr", timerClear, 1'b1);
      step();
      checkBit("down clr once", timerClear, 1'b0);
      step();
      check("down held", count(), expDown[i]);
      secondMarker = 1'b0;
      step();
    end
    checkBit("down running", bus.running, 1'b1);

    // Clear from RUNNING.
    pulseClear();
    check("clr count", count(), 16'h0000);
    checkBit("clr running", bus.running, 1'b0);
    checkBit("clr timerEnable", timerEnable, 1'b0);
    checkBit("clr timerClear", timerClear, 1'b1);

    // Start at 00:00 is ignored.
    pulseStart();
    checkBit("zero start ign", bus.running, 1'b0);
    checkBit("zero start clr", timerClear, 1'b0);

    // 3) Expiry and the timed alarm.
    load(4'd0, 4'd0, 4'd0, 4'd2);
    pulseStart();
    step();
    fullTick();
    check("exp 0001", count(), 16'h0001);
    fullTick();
    check("exp count", count(), 16'h0000);
    checkBit("exp alarm", bus.alarm, 1'b1);
    checkBit("exp running", bus.running, 1'b0);
    checkBit("exp timerEnable", timerEnable, 1'b1);
    for (int i = 0; i < 4; i++) begin
      fullTick();
      checkBit("alarm held", bus.alarm, 1'b1);
    end
    fullTick();
    checkBit("alarm done", bus.alarm, 1'b0);
    checkBit("alarm done en", timerEnable, 1'b0);
    check("alarm done cnt", count(), 16'h0000);

    // 4) Load rejection.
    load(4'd0, 4'd1, 4'd2, 4'd3);
    check("ld0123", count(), 16'h0123);
    load(4'd0, 4'd0, 4'd6, 4'd0);
    checkBit("secTens6 err", bus.loadError, 1'b1);
    check("secTens6 cnt", count(), 16'h0123);
    step();
    checkBit("err pulse 1cyc", bus.loadError, 1'b0);
    load(4'd6, 4'd0, 4'd0, 4'd0);
    checkBit("min60 err", bus.loadError, 1'b1);
    check("min60 cnt", count(), 16'h0123);
    load(4'd0, 4'd10, 4'd0, 4'd0);
    checkBit("nonbcd err", bus.loadError, 1'b1);
    check("nonbcd cnt", count(), 16'h0123);
    load(4'd5, 4'd9, 4'd5, 4'd9);
    checkBit("ld5959 err", bus.loadError, 1'b0);
    check("ld5959 cnt", count(), 16'h5959);
    pulseStart();
    load(4'd0, 4'd0, 4'd1, 4'd0);
    checkBit("run ld err", bus.loadError, 1'b0);
    check("run ld cnt", count(), 16'h5959);

    // 5) Tick and pause in the same cycle at 00:10.
    pulseClear();
    load(4'd0, 4'd0, 4'd1, 4'd0);
    pulseStart();
    step();
    secondMarker  = 1'b1;
    bus.startStop = 1'b1;
    step();
    bus.startStop = 1'b0;
    check("tp count", count(), 16'h0009);
    checkBit("tp running", bus.running, 1'b0);
    checkBit("tp timerEnable", timerEnable, 1'b0);
    checkBit("tp timerClear", timerClear, 1'b1);
    step();
    step();
    secondMarker = 1'b0;
    step();
    // A tick while paused re-arms the Timer but does not count.
    secondMarker = 1'b1;
    step();
    checkBit("pause tick clr", timerClear, 1'b1);
    check("pause tick cnt", count(), 16'h0009);
    secondMarker = 1'b0;
    step();
    pulseStart();
    checkBit("resume running", bus.running, 1'b1);
    checkBit("resume en", timerEnable, 1'b1);
    checkBit("resume no clr", timerClear, 1'b0);

    // 6) Asynchronous reset mid-run at 00:30.
    pulseClear();
    load(4'd0, 4'd0, 4'd3, 4'd0);
    pulseStart();
    step();
    reset = 1'b0;
    #2;
    check("arst count", count(), 16'h0000);
    checkBit("arst running", bus.running, 1'b0);
    checkBit("arst en", timerEnable, 1'b0);
    checkBit("arst clr", timerClear, 1'b1);
    reset = 1'b1;
    step();
    checkBit("arst rel clr", timerClear, 1'b0);

    // clearReq while EXPIRED.
    load(4'd0, 4'd0, 4'd0, 4'd1);
    pulseStart();
    step();
    fullTick();
    checkBit("exp2 alarm", bus.alarm, 1'b1);
    pulseClear();
    checkBit("clr exp alarm", bus.alarm, 1'b0);
    checkBit("clr exp en", timerEnable, 1'b0);
    checkBit("clr exp clr", timerClear, 1'b1);
    check("clr exp cnt", count(), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
